// File: rtl/ej1_input_cond_if.sv
// Signal bundle between the raw switch inputs, the conditioner and its consumers.
// master drives the raw levels and observes the cleaned outputs; slave is the conditioner.
interface ej1_input_cond_if;
    logic i_raw;
    logic s_raw;
    logic I;
    logic S;
    logic i_rise;
    logic i_fall;
    logic s_rise;
    logic s_fall;

    modport master (
        output i_raw, s_raw,
        input  I, S, i_rise, i_fall, s_rise, s_fall
    );

    modport slave (
        input  i_raw, s_raw,
        output I, S, i_rise, i_fall, s_rise, s_fall
    );
endinterface

// File: rtl/ej1_input_cond.sv
// Input conditioner for the ej1 I/S inputs: 2-FF synchroniser, per-channel debounce FSM,
// registered clean levels and one-cycle rise/fall pulses.
module ej1_input_cond #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ej1_input_cond_if.slave bus
);

    typedef enum logic [1:0] {StStableLo, StWaitHi, StStableHi, StWaitLo} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [1:0] raw;
    logic [1:0] out_w;
    logic [1:0] rise_w;
    logic [1:0] fall_w;

    // Channel 0 is I, channel 1 is S.
    assign raw        = {bus.s_raw, bus.i_raw};
    assign bus.I      = out_w[0];
    assign bus.S      = out_w[1];
    assign bus.i_rise = rise_w[0];
    assign bus.i_fall = fall_w[0];
    assign bus.s_rise = rise_w[1];
    assign bus.s_fall = fall_w[1];

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             rise_q;
        logic             fall_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= StStableLo;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync1_q <= raw[ch];
                sync2_q <= sync1_q;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                unique case (state_q)
                    StStableLo: begin
                        if (sync2_q) begin
                            state_q <= StWaitHi;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitHi: begin
                        if (!sync2_q) begin
                            state_q <= StStableLo;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StStableHi;
                            cnt_q   <= '0;
                            out_q   <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    StStableHi: begin
                        if (!sync2_q) begin
                            state_q <= StWaitLo;
                            cnt_q   <= CntOne;
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    StWaitLo: begin
                        if (sync2_q) begin
                            state_q <= StStableHi;
                            cnt_q   <= '0;
                        end else if (cnt_q == CntLast) begin
                            state_q <= StStableLo;
                            cnt_q   <= '0;
                            out_q   <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                    default: begin
                        state_q <= StStableLo;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign out_w[ch]  = out_q;
        assign rise_w[ch] = rise_q;
        assign fall_w[ch] = fall_q;
    end

endmodule

// File: tb/tb_ej1_input_cond.sv
// Self-checking bench for ej1_input_cond: directed scenarios plus randomized bouncing inputs,
// compared against a sample-history reference model.
module tb_ej1_input_cond;

    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ej1_input_cond_if bus ();

    ej1_input_cond #(
        .DB_CYCLES (DB),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: out flips once the last DB sampled (synchronised) values all differ from it.
    bit        m_s1   [2];
    bit        m_s2   [2];
    bit        m_out  [2];
    bit        m_rise [2];
    bit        m_fall [2];
    bit [31:0] m_hist [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_s1[ch] = 0; m_s2[ch] = 0; m_out[ch] = 0;
            m_rise[ch] = 0; m_fall[ch] = 0; m_hist[ch] = '0;
        end
    endtask

    task automatic model_step(input bit ir, input bit sr);
        bit        raw [2];
        bit        smp;
        bit [31:0] mask;
        raw[0] = ir;
        raw[1] = sr;
        mask = (32'd1 << DB) - 32'd1;
        for (int ch = 0; ch < 2; ch++) begin
            smp        = m_s2[ch];
            m_s2[ch]   = m_s1[ch];
            m_s1[ch]   = raw[ch];
            m_hist[ch] = {m_hist[ch][30:0], smp};
            m_rise[ch] = 0;
            m_fall[ch] = 0;
            if ((m_hist[ch] & mask) == (m_out[ch] ? 32'd0 : mask)) begin
                m_out[ch] = ~m_out[ch];
                if (m_out[ch]) m_rise[ch] = 1;
                else           m_fall[ch] = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".I"},      bus.I,      m_out[0]);
        check_eq({tag, ".S"},      bus.S,      m_out[1]);
        check_eq({tag, ".i_rise"}, bus.i_rise, m_rise[0]);
        check_eq({tag, ".i_fall"}, bus.i_fall, m_fall[0]);
        check_eq({tag, ".s_rise"}, bus.s_rise, m_rise[1]);
        check_eq({tag, ".s_fall"}, bus.s_fall, m_fall[1]);
        check_eq({tag, ".i_excl"}, bus.i_rise & bus.i_fall, 0);
        check_eq({tag, ".s_excl"}, bus.s_rise & bus.s_fall, 0);
    endtask

    // Drive raw levels, advance one edge, step the model and compare.
    task automatic cycle(input string tag, input bit ir, input bit sr);
        bus.i_raw = ir;
        bus.s_raw = sr;
        @(posedge clk);
        #1;
        model_step(ir, sr);
        check_all(tag);
    endtask

    task automatic settle_low();
        for (int k = 0; k < 12; k++) cycle("settle", 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int pulses;
        int s_pulses;
        int s_seen;
        bit ir, sr;
        int ilen, slen;

        // 1: reset held with raw inputs high
        model_reset();
        bus.i_raw = 1'b1;
        bus.s_raw = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
        n = 0; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle("reset_rel", 1'b1, 1'b1);
            pulses += bus.i_rise;
            if (n == 0 && bus.I) n = k + 1;
        end
        check_eq("reset_rel_edges", n, 6);
        check_eq("reset_rel_pulses", pulses, 1);

        // 2: clean step
        settle_low();
        n = 0; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            cycle("step", 1'b1, 1'b0);
            pulses += bus.i_rise;
            check_eq("step_no_fall", bus.i_fall, 0);
            if (n == 0 && bus.I) n = k + 1;
        end
        check_eq("step_edges", n, 6);
        check_eq("step_pulses", pulses, 1);

        // 3: bounce 1,1,1,0 then steady 1
        settle_low();
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            cycle("bounce", 1'b1, 1'b0);
            pulses += bus.i_rise;
        end
        cycle("bounce", 1'b0, 1'b0);
        pulses += bus.i_rise;
        n = 0;
        for (int k = 0; k < 14; k++) begin
            cycle("bounce", 1'b1, 1'b0);
            pulses += bus.i_rise;
            if (n == 0 && bus.I) n = k + 1;
        end
        check_eq("bounce_edges", n, 6);
        check_eq("bounce_pulses", pulses, 1);

        // 4: glitch on S shorter than the debounce window
        settle_low();
        s_pulses = 0; s_seen = 0;
        for (int k = 0; k < 15; k++) begin
            cycle("glitch", 1'b0, (k < 3));
            s_pulses += bus.s_rise + bus.s_fall;
            s_seen   += bus.S;
        end
        check_eq("glitch_pulses", s_pulses, 0);
        check_eq("glitch_level", s_seen, 0);

        // 5: simultaneous rise
        n = 0;
        for (int k = 0; k < 12; k++) begin
            cycle("simul", 1'b1, 1'b1);
            check_eq("simul_level", bus.S, bus.I);
            check_eq("simul_pulse", bus.s_rise, bus.i_rise);
            if (n == 0 && bus.I) n = k + 1;
        end
        check_eq("simul_edges", n, 6);

        // 6: async reset between edges 4 and 5 of an S count
        settle_low();
        s_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cycle("arst", 1'b0, 1'b1);
            s_pulses += bus.s_rise;
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst_hold");
        #1;
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            cycle("arst_rel", 1'b0, 1'b1);
            s_pulses += bus.s_rise;
            if (n == 0 && bus.S) n = k + 1;
        end
        check_eq("arst_edges", n, 6);
        check_eq("arst_pulses", s_pulses, 1);

        // Randomized bouncing: each channel holds a level for 1..7 cycles, then toggles.
        ir = 0; sr = 0; ilen = 1; slen = 1;
        for (int k = 0; k < 3000; k++) begin
            if (--ilen == 0) begin ir = ~ir; ilen = $urandom_range(1, 7); end
            if (--slen == 0) begin sr = ~sr; slen = $urandom_range(1, 7); end
            cycle("rand", ir, sr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
